pre_addr_priority_encoder_pipe: RTL
===================================

Name: pre_addr_priority_encoder_pipe

Overview:
- Parametrised, handshaked successor to the predecessor-address encoder in the Viterbi datapath.
- Accepts one predecessor-select vector per transfer, with one bit per POS tag, and encodes it to a tag index.
- Flags zero-hot and multi-hot vectors and counts them.
- Buffers results in a 2-entry skid FIFO so back-pressure from the traceback/backpointer store never drops a vector.

Parameters:
- POS_num, 11, width of the input vector (number of POS tags); must be >= 2.
- POS_num_bit, 4, output index width; must satisfy 2^POS_num_bit >= POS_num.
- MSB_PRIORITY, 1, 1 = highest set bit wins; 0 = lowest set bit wins.
- ERR_CNT_W, 8, width of the saturating error counter.

Ports:
- clk, input, 1, clock; all state updates on rising edge.
- reset, input, 1, synchronous active-low reset.
- in_valid, input, 1, in_vec is valid.
- in_ready, output, 1, block can accept in_vec this cycle.
- in_vec, input, POS_num, predecessor-select vector.
- out_valid, output, 1, head entry valid.
- out_ready, input, 1, consumer takes the head entry this cycle.
- out_idx, output, POS_num_bit, encoded index of the head entry.
- out_none, output, 1, head entry came from an all-zero vector.
- out_multi, output, 1, head entry came from a vector with two or more bits set.
- clr_cnt, input, 1, synchronous clear of err_cnt.
- err_cnt, output, ERR_CNT_W, saturating count of accepted zero-hot or multi-hot vectors.

Behaviour:
- Reset: reset is synchronous, active-low; clock is clk.
  - While reset=0 at a rising edge: FIFO count=0, out_valid=0, out_idx=0, out_none=0, out_multi=0, err_cnt=0.
  - in_ready=0 during any cycle with reset=0.
  - Reset mid-operation discards all buffered entries; no partial output.
- Transfers:
  - Push = in_valid & in_ready. Pop = out_valid & out_ready.
  - in_ready = reset & (count < 2). It is registered-state-derived and does not depend on out_ready, so there is no combinational ready path.
- Encoding, computed on the push cycle and stored with the entry:
  - MSB_PRIORITY=1: idx = highest i with in_vec[i]=1.
  - MSB_PRIORITY=0: idx = lowest such i.
  - Zero-hot: idx=0, none=1, multi=0.
  - Multi-hot: idx per priority, multi=1, none=0.
  - Exactly one bit set: none=0, multi=0.
- Latency:
  - A vector pushed at edge N is visible on out_* after edge N, i.e. 1 cycle, when the FIFO was empty or popping.
  - Order is strictly FIFO.
- Count update:
  - push only: +1.
  - pop only: -1.
  - push & pop: unchanged. This is legal only at count=1; at count=2, in_ready=0.
  - Pop at count=1 with a simultaneous push: the new entry becomes head on the next cycle, and out_valid stays 1.
- Output stability: out_valid=1 with out_ready=0 holds out_idx, out_none and out_multi stable until popped.
- out_valid = (count != 0).
- When empty, out_idx, out_none and out_multi hold their last values; consumers ignore them.
- err_cnt:
  - Increments by 1 on a push whose vector is zero-hot or multi-hot.
  - Saturates at 2^ERR_CNT_W-1; no wrap.
  - clr_cnt=1 sets err_cnt=0 and has priority over a same-cycle increment.
  - Not affected by pops.
- in_vec is ignored when in_valid=0; out_ready is ignored when out_valid=0.
- No X propagation: all storage is reset.

Test Plan:
1. Reset then single one-hot: reset=0 for 2 cycles, then in_vec=11'b000_0010_0000, in_valid=1 for 1 cycle, out_ready=1 → next cycle out_valid=1, out_idx=5, none=0, multi=0; err_cnt=0.
2. Priority modes: in_vec=11'b100_0000_1000 → MSB_PRIORITY=1 gives out_idx=10, multi=1; MSB_PRIORITY=0 gives out_idx=3, multi=1; err_cnt=1.
3. Zero-hot: in_vec=0 pushed → out_idx=0, none=1, multi=0; err_cnt increments to 1.
4. Back-pressure/full: out_ready=0, push bit2 then bit7 → in_ready=0 after second push; a third vector held on in_vec is not accepted. Raise out_ready → outputs idx 2 then 7 on consecutive cycles, then the third vector appears; no loss or duplication.
5. Simultaneous push/pop at count=1 over 20 random streaming cycles with out_ready=1 → out_valid stays 1, output sequence equals input sequence delayed by 1 cycle.
6. Counter saturation and clear: ERR_CNT_W=2, push 5 zero-hot vectors → err_cnt=3 (saturated). Then assert clr_cnt in the same cycle as a zero-hot push → err_cnt=0. Then assert reset=0 with 2 entries buffered → out_valid=0, err_cnt=0 next cycle.

Source files
------------

// File: rtl/pre_addr_priority_encoder_pipe.sv
// Predecessor-select priority encoder for the Viterbi datapath. Each accepted vector
// is encoded to a tag index with zero/multi-hot flags, then buffered in a 2-entry skid FIFO.
module pre_addr_priority_encoder_pipe #(
  parameter int POS_num      = 11,
  parameter int POS_num_bit  = 4,
  parameter int MSB_PRIORITY = 1,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [POS_num-1:0]     in_vec,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [POS_num_bit-1:0] out_idx,
  output logic                   out_none,
  output logic                   out_multi,
  input  logic                   clr_cnt,
  output logic [ERR_CNT_W-1:0]   err_cnt
);

  typedef struct packed {
    logic [POS_num_bit-1:0] idx;
    logic                   none;
    logic                   multi;
  } entry_t;

  entry_t     enc;
  entry_t     head, tail;
  logic [1:0] count;
  logic       seen;
  logic       push, pop;

  // Scan from bit 0 upward: MSB mode keeps overwriting, LSB mode keeps the first hit.
  always_comb begin
    enc  = '0;
    seen = 1'b0;
    for (int i = 0; i < POS_num; i++) begin
      if (in_vec[i]) begin
        if (MSB_PRIORITY != 0 || !seen) enc.idx = POS_num_bit'(i);
        if (seen) enc.multi = 1'b1;
        seen = 1'b1;
      end
    end
    enc.none = !seen;
  end

  // Ready comes from registered count only, so out_ready never reaches in_ready.
  assign in_ready  = reset & (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= 2'd0;
      head  <= '0;
      tail  <= '0;
    end else begin
      // Head register doubles as the output; it keeps its last value when empty.
      if (pop && count == 2'd2)
        head <= tail;
      else if (push && (count == 2'd0 || pop))
        head <= enc;

      if (push && !pop && count == 2'd1)
        tail <= enc;

      if (push && !pop)
        count <= count + 2'd1;
      else if (pop && !push)
        count <= count - 2'd1;
    end
  end

  assign out_idx   = head.idx;
  assign out_none  = head.none;
  assign out_multi = head.multi;

  always_ff @(posedge clk) begin
    if (!reset)
      err_cnt <= '0;
    else if (clr_cnt)
      err_cnt <= '0;
    else if (push && (enc.none || enc.multi) && err_cnt != {ERR_CNT_W{1'b1}})
      err_cnt <= err_cnt + 1'b1;
  end

endmodule
